// File: rtl/boot_loader.sv
// Boot sequencer: streams an instruction image and a data image into CPU memories,
// runs the CPU for a fixed number of cycles, then streams selected data words back out.
module boot_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [31:0] run_cycles,
    input  logic [10:0] rb_count,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic        rb_valid,
    input  logic        rb_ready,
    output logic [63:0] rb_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable
);

    typedef enum logic [2:0] {
        IDLE, LOAD_I, LOAD_D, RUN, RD_REQ, RD_WAIT, RD_OUT, FIN
    } state_t;

    localparam logic [31:0] IMEM_DEPTH = IMEM_WORDS;
    localparam logic [31:0] DMEM_DEPTH = DMEM_WORDS;

    state_t      state;
    state_t      state_next;
    logic [11:0] index;
    logic [31:0] run_cfg;
    logic [31:0] run_left;
    logic [11:0] rb_limit;
    logic        wr_room;
    logic        unused_rdata;

    // The instruction port is write-only from the loader's side.
    assign unused_rdata = ^rdata_ext;

    assign wr_room = (state == LOAD_D) ? (32'(index) < DMEM_DEPTH)
                                       : (32'(index) < IMEM_DEPTH);
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            index    <= 12'd0;
            overflow <= 1'b0;
            run_cfg  <= 32'd0;
            run_left <= 32'd0;
            rb_limit <= 12'd0;
            rb_data  <= 64'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        index    <= 12'd0;
                        overflow <= 1'b0;
                        run_cfg  <= run_cycles;
                        rb_limit <= (32'(rb_count) > DMEM_DEPTH) ? 12'(DMEM_WORDS)
                                                                 : {1'b0, rb_count};
                    end
                end
                LOAD_I, LOAD_D: begin
                    if (in_valid) begin
                        if (!wr_room) begin
                            overflow <= 1'b1;
                        end
                        // Saturate rather than wrap so late beats can never alias low addresses.
                        if (in_last) begin
                            index <= 12'd0;
                        end else if (index != 12'hFFF) begin
                            index <= index + 12'd1;
                        end
                        if (state == LOAD_D && in_last) begin
                            run_left <= run_cfg;
                        end
                    end
                end
                RUN:     run_left <= run_left - 32'd1;
                RD_WAIT: rb_data  <= rdata_ext_2;
                RD_OUT: begin
                    if (rb_ready) begin
                        index <= index + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        addr_ext    = 64'd0;
        wdata_ext   = 32'd0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = 64'd0;
        wdata_ext_2 = 64'd0;
        cpu_enable  = 1'b0;
        rb_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_I;
                end
            end
            LOAD_I: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (wr_room) begin
                        wen_ext   = 1'b1;
                        addr_ext  = {50'd0, index, 2'b00};
                        wdata_ext = in_data[31:0];
                    end
                    if (in_last) begin
                        state_next = LOAD_D;
                    end
                end
            end
            LOAD_D: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (wr_room) begin
                        wen_ext_2   = 1'b1;
                        addr_ext_2  = {49'd0, index, 3'b000};
                        wdata_ext_2 = in_data;
                    end
                    if (in_last) begin
                        state_next = (run_cfg == 32'd0) ? RD_REQ : RUN;
                    end
                end
            end
            RUN: begin
                cpu_enable = 1'b1;
                if (run_left == 32'd1) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                if (index == rb_limit) begin
                    state_next = FIN;
                end else begin
                    ren_ext_2  = 1'b1;
                    addr_ext_2 = {49'd0, index, 3'b000};
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: state_next = RD_OUT;
            RD_OUT: begin
                rb_valid = 1'b1;
                if (rb_ready) begin
                    state_next = RD_REQ;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: load/run/readback flow, backpressure, overflow,
// zero-length run and readback, mid-run reset and ignored start.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] run_cycles = 32'd0;
    logic [10:0] rb_count = 11'd0;
    logic        busy, done, overflow;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        in_last = 1'b0;
    logic        rb_valid;
    logic        rb_ready = 1'b1;
    logic [63:0] rb_data;
    logic [63:0] addr_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = 32'd0;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2, ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = 64'd0;
    logic        cpu_enable;

    int n_checks = 0;
    int n_pass = 0;

    int wen_i_cnt = 0;
    int ren_i_cnt = 0;
    int wen_d_cnt = 0;
    int ren_d_cnt = 0;
    int cpu_cnt = 0;
    int done_cnt = 0;
    logic [63:0] waddr_i_q[$];
    logic [31:0] wdata_i_q[$];
    logic [63:0] waddr_d_q[$];
    logic [63:0] rb_q[$];
    logic [63:0] dmem[64];

    boot_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .run_cycles(run_cycles),
        .rb_count(rb_count), .busy(busy), .done(done), .overflow(overflow),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_data(rb_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .cpu_enable(cpu_enable)
    );

    always #5 clk = ~clk;

    // Bus monitor plus a one-cycle-latency data memory model.
    always @(posedge clk) begin
        if (wen_ext) begin
            wen_i_cnt++;
            waddr_i_q.push_back(addr_ext);
            wdata_i_q.push_back(wdata_ext);
        end
        if (ren_ext) ren_i_cnt++;
        if (wen_ext_2) begin
            wen_d_cnt++;
            waddr_d_q.push_back(addr_ext_2);
            dmem[addr_ext_2[8:3]] <= wdata_ext_2;
        end
        if (ren_ext_2) begin
            ren_d_cnt++;
            rdata_ext_2 <= dmem[addr_ext_2[8:3]];
        end
        if (cpu_enable) cpu_cnt++;
        if (done) done_cnt++;
        if (rb_valid && rb_ready) rb_q.push_back(rb_data);
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_start(input logic [31:0] rc, input logic [10:0] rbc);
        @(negedge clk);
        start = 1'b1; run_cycles = rc; rb_count = rbc;
        @(negedge clk);
        start = 1'b0; run_cycles = 32'd0; rb_count = 11'd0;
    endtask

    task automatic load_seg(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = base + 64'(i); in_last = (i == n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = 64'd0;
    endtask

    task automatic wait_done(input int base, input string name);
        int i;
        for (i = 0; i < 200 && done_cnt == base; i++) @(negedge clk);
        n_checks++;
        if (done_cnt == base) $display("[TB] FAIL %s_timeout: got no done within %0d cycles, required a done pulse", name, i);
        else n_pass++;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (done !== 1'b0 || overflow !== 1'b0) $display("[TB] FAIL reset_done_ovf: got %b%b expected 00", done, overflow); else n_pass++;
        n_checks++; if (cpu_enable !== 1'b0 || rb_valid !== 1'b0) $display("[TB] FAIL reset_cpu_rbv: got %b%b expected 00", cpu_enable, rb_valid); else n_pass++;
        n_checks++; if (rb_data !== 64'd0) $display("[TB] FAIL reset_rb_data: got %h expected 0", rb_data); else n_pass++;
        n_checks++; if ({wen_ext, ren_ext, wen_ext_2, ren_ext_2} !== 4'b0) $display("[TB] FAIL reset_enables: got %b expected 0000", {wen_ext, ren_ext, wen_ext_2, ren_ext_2}); else n_pass++;
        n_checks++; if (addr_ext !== 64'd0 || wdata_ext !== 32'd0 || addr_ext_2 !== 64'd0 || wdata_ext_2 !== 64'd0) $display("[TB] FAIL reset_addr_data: got %h %h %h %h expected all 0", addr_ext, wdata_ext, addr_ext_2, wdata_ext_2); else n_pass++;
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_idle_wait: got busy %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_basic;
        int wi = wen_i_cnt, wd = wen_d_cnt, ri = ren_i_cnt, cc = cpu_cnt, dc = done_cnt;
        int qi = waddr_i_q.size(), qd = waddr_d_q.size(), qr = rb_q.size();
        logic [63:0] exp_rb[2];
        exp_rb[0] = 64'hA5A5_5A5A_0000_1000;
        exp_rb[1] = 64'hA5A5_5A5A_0000_1001;
        rb_ready = 1'b1;
        do_start(32'd5, 11'd2);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("[TB] FAIL basic_load_i_entry: got busy %b in_ready %b expected 1 1", busy, in_ready); else n_pass++;
        load_seg(3, 64'hFFFF_0000_C0DE_0000);
        n_checks++; if (wen_i_cnt - wi !== 3) $display("[TB] FAIL basic_wen_i_count: got %0d expected 3", wen_i_cnt - wi); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (waddr_i_q[qi + k] !== 64'(4 * k)) $display("[TB] FAIL basic_addr_i%0d: got %h expected %h", k, waddr_i_q[qi + k], 64'(4 * k)); else n_pass++;
        end
        n_checks++; if (wdata_i_q[qi + 2] !== 32'hC0DE_0002) $display("[TB] FAIL basic_wdata_i2: got %h expected c0de0002", wdata_i_q[qi + 2]); else n_pass++;
        load_seg(2, 64'hA5A5_5A5A_0000_1000);
        n_checks++; if (wen_d_cnt - wd !== 2) $display("[TB] FAIL basic_wen_d_count: got %0d expected 2", wen_d_cnt - wd); else n_pass++;
        n_checks++; if (waddr_d_q[qd] !== 64'd0 || waddr_d_q[qd + 1] !== 64'd8) $display("[TB] FAIL basic_addr_d: got %h %h expected 0 8", waddr_d_q[qd], waddr_d_q[qd + 1]); else n_pass++;
        wait_done(dc, "basic");
        n_checks++; if (cpu_cnt - cc !== 5) $display("[TB] FAIL basic_cpu_cycles: got %0d expected 5", cpu_cnt - cc); else n_pass++;
        n_checks++; if (rb_q.size() - qr !== 2) $display("[TB] FAIL basic_rb_beats: got %0d expected 2", rb_q.size() - qr); else n_pass++;
        for (int k = 0; k < 2 && qr + k < rb_q.size(); k++) begin
            n_checks++; if (rb_q[qr + k] !== exp_rb[k]) $display("[TB] FAIL basic_rb_data%0d: got %h expected %h", k, rb_q[qr + k], exp_rb[k]); else n_pass++;
        end
        n_checks++; if (done_cnt - dc !== 1) $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt - dc); else n_pass++;
        n_checks++; if (ren_i_cnt - ri !== 0) $display("[TB] FAIL basic_ren_ext: got %0d expected 0", ren_i_cnt - ri); else n_pass++;
        n_checks++; if (busy !== 1'b0 || overflow !== 1'b0) $display("[TB] FAIL basic_end_state: got busy %b ovf %b expected 0 0", busy, overflow); else n_pass++;
    endtask

    task automatic test_backpressure;
        int rd = ren_d_cnt, dc = done_cnt, qr = rb_q.size();
        int waited;
        int bad = 0;
        rb_ready = 1'b0;
        do_start(32'd2, 11'd1);
        load_seg(1, 64'h0);
        load_seg(1, 64'h0BAD_F00D_CAFE_1234);
        for (waited = 0; waited < 50 && rb_valid !== 1'b1; waited++) @(negedge clk);
        n_checks++; if (rb_valid !== 1'b1) $display("[TB] FAIL bp_rb_valid_timeout: got %b expected 1 within 50 cycles", rb_valid); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (rb_valid !== 1'b1 || rb_data !== 64'h0BAD_F00D_CAFE_1234) $display("[TB] FAIL bp_hold%0d: got valid %b data %h expected 1 0badf00dcafe1234", k, rb_valid, rb_data);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (ren_d_cnt - rd !== 1) $display("[TB] FAIL bp_ren_count: got %0d expected 1", ren_d_cnt - rd); else n_pass++;
        rb_ready = 1'b1;
        wait_done(dc, "bp");
        n_checks++; if (rb_q.size() - qr !== 1) $display("[TB] FAIL bp_rb_beats: got %0d expected 1", rb_q.size() - qr); else n_pass++;
        n_checks++; if (ren_d_cnt - rd !== 1) $display("[TB] FAIL bp_ren_final: got %0d expected 1", ren_d_cnt - rd); else n_pass++;
        if (bad != 0) n_checks++;
    endtask

    task automatic test_overflow;
        int wi = wen_i_cnt, dc = done_cnt, qi = waddr_i_q.size();
        do_start(32'd1, 11'd0);
        load_seg(513, 64'h7000_0000);
        n_checks++; if (wen_i_cnt - wi !== 512) $display("[TB] FAIL ovf_write_count: got %0d expected 512", wen_i_cnt - wi); else n_pass++;
        n_checks++; if (waddr_i_q[qi + 511] !== 64'd2044) $display("[TB] FAIL ovf_last_addr: got %h expected 7fc", waddr_i_q[qi + 511]); else n_pass++;
        n_checks++; if (overflow !== 1'b1 || in_ready !== 1'b1) $display("[TB] FAIL ovf_flag: got ovf %b in_ready %b expected 1 1", overflow, in_ready); else n_pass++;
        load_seg(1, 64'h1);
        wait_done(dc, "ovf");
        n_checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); else n_pass++;
    endtask

    task automatic test_zero;
        int cc = cpu_cnt, rd = ren_d_cnt, dc = done_cnt;
        do_start(32'd0, 11'd0);
        n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL zero_ovf_cleared: got %b expected 0", overflow); else n_pass++;
        load_seg(1, 64'h2);
        load_seg(1, 64'h3);
        n_checks++; if (done !== 1'b0 || busy !== 1'b1 || ren_ext_2 !== 1'b0) $display("[TB] FAIL zero_rd_req: got done %b busy %b ren2 %b expected 0 1 0", done, busy, ren_ext_2); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) $display("[TB] FAIL zero_done_cycle: got %b expected 1", done); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL zero_after_done: got done %b busy %b expected 0 0", done, busy); else n_pass++;
        n_checks++; if (cpu_cnt - cc !== 0 || ren_d_cnt - rd !== 0) $display("[TB] FAIL zero_no_activity: got cpu %0d ren2 %0d expected 0 0", cpu_cnt - cc, ren_d_cnt - rd); else n_pass++;
        n_checks++; if (done_cnt - dc !== 1) $display("[TB] FAIL zero_done_count: got %0d expected 1", done_cnt - dc); else n_pass++;
    endtask

    task automatic test_reset_run;
        int cc, dc, qr;
        do_start(32'd10, 11'd1);
        load_seg(1, 64'h4);
        load_seg(1, 64'h5);
        n_checks++; if (cpu_enable !== 1'b1) $display("[TB] FAIL rr_running: got %b expected 1", cpu_enable); else n_pass++;
        @(negedge clk); @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        n_checks++; if (cpu_enable !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rr_async_clear: got cpu %b busy %b expected 0 0", cpu_enable, busy); else n_pass++;
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++; if (busy !== 1'b0 || cpu_enable !== 1'b0) $display("[TB] FAIL rr_idle_after: got busy %b cpu %b expected 0 0", busy, cpu_enable); else n_pass++;
        cc = cpu_cnt; dc = done_cnt; qr = rb_q.size();
        do_start(32'd3, 11'd1);
        load_seg(1, 64'h6);
        load_seg(1, 64'h1234_5678_9ABC_DEF0);
        wait_done(dc, "rr");
        n_checks++; if (cpu_cnt - cc !== 3) $display("[TB] FAIL rr_cpu_cycles: got %0d expected 3", cpu_cnt - cc); else n_pass++;
        n_checks++; if (rb_q.size() - qr !== 1 || rb_q[rb_q.size() - 1] !== 64'h1234_5678_9ABC_DEF0) $display("[TB] FAIL rr_rb_data: got %0d beats last %h expected 1 beat 123456789abcdef0", rb_q.size() - qr, rb_q[rb_q.size() - 1]); else n_pass++;
    endtask

    task automatic test_start_ignored;
        int wi = wen_i_cnt, cc = cpu_cnt, dc = done_cnt, qd = waddr_d_q.size(), qr = rb_q.size();
        do_start(32'd2, 11'd1);
        load_seg(1, 64'h7);
        in_valid = 1'b1; in_data = 64'h5555_0000_0000_0001; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("[TB] FAIL si_still_load_d: got busy %b in_ready %b expected 1 1", busy, in_ready); else n_pass++;
        in_valid = 1'b1; in_data = 64'h5555_0000_0000_0002; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(dc, "si");
        n_checks++; if (waddr_d_q.size() - qd !== 2 || waddr_d_q[qd + 1] !== 64'd8) $display("[TB] FAIL si_addr_d: got %0d writes second %h expected 2 writes second 8", waddr_d_q.size() - qd, waddr_d_q[qd + 1]); else n_pass++;
        n_checks++; if (wen_i_cnt - wi !== 1) $display("[TB] FAIL si_wen_i: got %0d expected 1", wen_i_cnt - wi); else n_pass++;
        n_checks++; if (cpu_cnt - cc !== 2) $display("[TB] FAIL si_cpu_cycles: got %0d expected 2", cpu_cnt - cc); else n_pass++;
        n_checks++; if (rb_q.size() - qr !== 1 || rb_q[rb_q.size() - 1] !== 64'h5555_0000_0000_0001) $display("[TB] FAIL si_rb_data: got %0d beats last %h expected 1 beat 5555000000000001", rb_q.size() - qr, rb_q[rb_q.size() - 1]); else n_pass++;
        n_checks++; if (done_cnt - dc !== 1) $display("[TB] FAIL si_done_count: got %0d expected 1", done_cnt - dc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_zero();
        test_reset_run();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
